// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words, writes them to
// instruction memory, and holds the CPU in reset until the program has fully loaded.
module imem_loader #(
    parameter int unsigned NWORDS  = 64,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic        WE,
    output logic [5:0]  WA,
    output logic [31:0] WD,
    output logic        CPU_RESET,
    output logic        DONE,
    output logic        ERROR
);

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] LAST_WORD  = AW'(NWORDS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_FIN   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t        state_q,     state_d;
    logic [1:0]    byte_cnt_q,  byte_cnt_d;
    logic [AW-1:0] word_cnt_q,  word_cnt_d;
    logic [TW-1:0] timer_q,     timer_d;
    // only the first three bytes need storage; the fourth goes straight into WD
    logic [23:0]   asm_q,       asm_d;
    logic [AW-1:0] wa_q,        wa_d;
    logic [DW-1:0] wd_q,        wd_d;
    logic          rx_ready_q,  rx_ready_d;
    logic          we_q,        we_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          done_q,      done_d;
    logic          error_q,     error_d;
    logic          accept_c;

    // next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        timer_d    = timer_q;
        asm_d      = asm_q;
        wa_d       = wa_q;
        wd_d       = wd_q;
        accept_c   = (state_q == S_LOAD) && RX_VALID;

        case (state_q)
            S_IDLE, S_FIN, S_ERR: begin
                if (START) begin
                    state_d    = S_LOAD;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    timer_d    = '0;
                    asm_d      = '0;
                end
            end
            S_LOAD: begin
                if (accept_c) begin
                    // acceptance beats a timeout falling on the same cycle
                    timer_d    = '0;
                    asm_d      = {asm_q[15:0], RX_DATA};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        wa_d    = word_cnt_q;
                        wd_d    = {asm_q, RX_DATA};
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q == TIMER_LAST) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WRITE: begin
                if (word_cnt_q == LAST_WORD) begin
                    state_d = S_FIN;
                end else begin
                    word_cnt_d = word_cnt_q + AW'(1);
                    state_d    = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rx_ready_d  = (state_d == S_LOAD);
        we_d        = (state_d == S_WRITE);
        cpu_reset_d = (state_d != S_FIN);
        done_d      = (state_d == S_FIN);
        error_d     = (state_d == S_ERR);
    end

    // state and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            word_cnt_q  <= '0;
            timer_q     <= '0;
            asm_q       <= '0;
            wa_q        <= '0;
            wd_q        <= '0;
            rx_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            timer_q     <= timer_d;
            asm_q       <= asm_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            rx_ready_q  <= rx_ready_d;
            we_q        <= we_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign RX_READY  = rx_ready_q;
    assign WE        = we_q;
    assign WA        = wa_q;
    assign WD        = wd_q;
    assign CPU_RESET = cpu_reset_q;
    assign DONE      = done_q;
    assign ERROR     = error_q;

endmodule
